// File: rtl/fir_serdes_pkg.sv
// Shared types and helpers for the fir_filter serial front end.
package fir_serdes_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   localparam int DEFAULT_LENGTH = 24;
   // Widest word the parity helper covers; callers zero-extend into it.
   localparam int PARITY_MAX_W   = 64;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/word_serializer.sv
// LSB-first parallel-to-serial converter with frame-last flag and idle gap.
// Optional macro WORD_SERIALIZER_PARITY_EN appends an even-parity bit to each frame.
module word_serializer
   import fir_serdes_pkg::*;
#(
   parameter int LENGTH     = DEFAULT_LENGTH,
   parameter int GAP_CYCLES = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [LENGTH-1:0] i_word,
   input  logic              i_word_valid,
   output logic              o_word_ready,
   output logic              o_dout,
   output logic              o_dout_en,
   output logic              o_dout_last,
   output logic              o_busy
);

`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int FRAME_LEN = LENGTH + 1;
`else
   localparam int FRAME_LEN = LENGTH;
`endif
   localparam int CW = cnt_width(FRAME_LEN);
   localparam int GW = (GAP_CYCLES > 0) ? cnt_width(GAP_CYCLES) : 1;

   state_t               state;
   logic [FRAME_LEN-1:0] shreg;
   logic [FRAME_LEN-1:0] load_word;
   logic [CW-1:0]        cnt;
   logic [GW-1:0]        gcnt;
   logic                 dout_en_q;

   always_comb begin
`ifdef WORD_SERIALIZER_PARITY_EN
      load_word = {even_parity(PARITY_MAX_W'(i_word)), i_word};
`else
      load_word = i_word;
`endif
   end

   assign o_word_ready = (state == IDLE) && i_en && !i_rst;
   assign o_busy       = (state != IDLE);
   // A stalled cycle must not look like a frame bit to the downstream stage.
   assign o_dout_en    = dout_en_q && i_en;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         shreg       <= '0;
         cnt         <= '0;
         gcnt        <= '0;
         o_dout      <= 1'b0;
         dout_en_q   <= 1'b0;
         o_dout_last <= 1'b0;
      end else if (i_en) begin
         case (state)
            IDLE: begin
               if (i_word_valid) begin
                  shreg       <= load_word;
                  cnt         <= '0;
                  state       <= SHIFT;
                  o_dout      <= load_word[0];
                  dout_en_q   <= 1'b1;
                  o_dout_last <= 1'b0;
               end
            end
            SHIFT: begin
               if (cnt == CW'(FRAME_LEN - 1)) begin
                  state       <= (GAP_CYCLES == 0) ? IDLE : GAP;
                  cnt         <= '0;
                  gcnt        <= '0;
                  o_dout      <= 1'b0;
                  dout_en_q   <= 1'b0;
                  o_dout_last <= 1'b0;
               end else begin
                  // Outputs are registered, so look one bit ahead of the shift.
                  shreg       <= shreg >> 1;
                  cnt         <= cnt + CW'(1);
                  o_dout      <= shreg[1];
                  o_dout_last <= (cnt == CW'(FRAME_LEN - 2));
               end
            end
            GAP: begin
               if (gcnt == GW'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
                  gcnt  <= '0;
               end else begin
                  gcnt  <= gcnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: per-cycle output log, frames decoded from the log.
module tb_word_serializer;

   localparam int LENGTH = 24;
   localparam int GAP    = 1;
`ifdef WORD_SERIALIZER_PARITY_EN
   localparam int FL = LENGTH + 1;
`else
   localparam int FL = LENGTH;
`endif
   localparam int LOGN = 2048;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic              i_en  = 1'b1;
   logic [LENGTH-1:0] i_word = '0;
   logic              i_word_valid = 1'b0;
   logic              o_word_ready, o_dout, o_dout_en, o_dout_last, o_busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic lg_en[LOGN], lg_dout[LOGN], lg_last[LOGN], lg_ready[LOGN], lg_busy[LOGN], lg_valid[LOGN];

   word_serializer #(.LENGTH(LENGTH), .GAP_CYCLES(GAP)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_word(i_word),
      .i_word_valid(i_word_valid), .o_word_ready(o_word_ready), .o_dout(o_dout),
      .o_dout_en(o_dout_en), .o_dout_last(o_dout_last), .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample the cycle at negedge, then advance past the next rising edge.
   task automatic tick();
      @(negedge i_clk);
      if (cyc < LOGN) begin
         lg_en[cyc]    = o_dout_en;
         lg_dout[cyc]  = o_dout;
         lg_last[cyc]  = o_dout_last;
         lg_ready[cyc] = o_word_ready;
         lg_busy[cyc]  = o_busy;
         lg_valid[cyc] = i_word_valid;
      end
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [LENGTH-1:0] wd, input bit keep, output int acc);
      i_word = wd;
      i_word_valid = 1'b1;
      acc = -1;
      for (int k = 0; k < 100 && acc < 0; k++) begin
         tick();
         if (lg_ready[cyc-1] && lg_valid[cyc-1]) acc = cyc - 1;
      end
      if (!keep) i_word_valid = 1'b0;
      if (acc < 0) begin
         chk("accept_timeout", 32'd0, 32'd1);
         acc = cyc - 1;
      end
   endtask

   task automatic decode(input int from, input int n, output logic [31:0] w, output int nbits,
                         output int nlast, output int last_idx, output int last_cyc,
                         output int first_cyc);
      w = '0; nbits = 0; nlast = 0; last_idx = -1; last_cyc = -1; first_cyc = -1;
      for (int c = from; c < from + n && c < LOGN; c++) begin
         if (lg_en[c]) begin
            if (nbits < 32) w[nbits] = lg_dout[c];
            if (nbits == 0) first_cyc = c;
            if (lg_last[c]) begin
               nlast++;
               last_idx = nbits;
               last_cyc = c;
            end
            nbits++;
         end
      end
   endtask

   initial begin
      int acc, acc2, nb, nl, li, lc, fc, fc2, cnt;
      logic [31:0] w;
      logic [LENGTH-1:0] wd;

      // Reset state
      repeat (2) tick();
      chk("rst_busy",  32'(lg_busy[1]),  32'd0);
      chk("rst_en",    32'(lg_en[1]),    32'd0);
      chk("rst_last",  32'(lg_last[1]),  32'd0);
      chk("rst_dout",  32'(lg_dout[1]),  32'd0);
      chk("rst_ready", 32'(lg_ready[1]), 32'd0);
      i_rst = 1'b0;
      tick();
      chk("idle_ready", 32'(lg_ready[cyc-1]), 32'd1);

      // Single frame A5C3F0
      send(24'hA5C3F0, 1'b0, acc);
      repeat (FL + 4) tick();
      decode(acc + 1, FL + 4, w, nb, nl, li, lc, fc);
      chk("a5_first8",  w & 32'hFF, 32'hF0);
      chk("a5_word",    w & 32'hFFFFFF, 32'hA5C3F0);
      chk("a5_en_cnt",  32'(nb), 32'(FL));
      chk("a5_last_n",  32'(nl), 32'd1);
      chk("a5_last_ix", 32'(li), 32'(FL - 1));
      chk("a5_latency", 32'(fc - acc), 32'd1);
`ifdef WORD_SERIALIZER_PARITY_EN
      chk("a5_parity",  32'(w[24]), 32'd0);
`endif

      // Back-to-back words with valid held high
      send(24'h000001, 1'b1, acc);
      send(24'hFFFFFF, 1'b0, acc2);
      repeat (FL + 4) tick();
      chk("b2b_period", 32'(acc2 - acc), 32'(FL + GAP + 1));
      cnt = 0;
      for (int c = acc + 1; c < acc2; c++) if (!lg_ready[c]) cnt++;
      chk("b2b_notready", 32'(cnt), 32'(FL + GAP));
      decode(acc + 1, acc2 - acc, w, nb, nl, li, lc, fc);
      chk("b2b_word1", w & 32'hFFFFFF, 32'h000001);
      decode(acc2 + 1, FL + 3, w, nb, nl, li, lc, fc2);
      chk("b2b_word2", w & 32'hFFFFFF, 32'hFFFFFF);
      chk("b2b_bit0_gap", 32'(fc2 - fc), 32'(FL + GAP + 1));

      // Three-cycle stall while bit 10 is on the line
      wd = 24'h3C96E1;
      send(wd, 1'b0, acc);
      repeat (10) tick();
      i_en = 1'b0;
      repeat (3) tick();
      i_en = 1'b1;
      repeat (FL + 4) tick();
      for (int c = acc + 11; c <= acc + 13; c++) begin
         chk("stall_en",   32'(lg_en[c]),   32'd0);
         chk("stall_dout", 32'(lg_dout[c]), 32'(wd[10]));
      end
      decode(acc + 1, FL + 6, w, nb, nl, li, lc, fc);
      chk("stall_word", w & 32'hFFFFFF, 32'h3C96E1);
      chk("stall_last", 32'(lc - acc), 32'(FL + 3));

      // Reset mid-frame, with a handshake offered during the reset cycle
      send(24'h123456, 1'b0, acc);
      repeat (12) tick();
      i_rst = 1'b1;
      i_word = 24'hABCDEF;
      i_word_valid = 1'b1;
      tick();
      chk("rst_mid_ready", 32'(lg_ready[cyc-1]), 32'd0);
      i_rst = 1'b0;
      tick();
      acc2 = cyc - 1;
      i_word_valid = 1'b0;
      chk("rst_after_busy",  32'(lg_busy[acc2]),  32'd0);
      chk("rst_after_en",    32'(lg_en[acc2]),    32'd0);
      chk("rst_after_last",  32'(lg_last[acc2]),  32'd0);
      chk("rst_after_ready", 32'(lg_ready[acc2]), 32'd1);
      repeat (FL + 4) tick();
      decode(acc + 1, acc2 - acc, w, nb, nl, li, lc, fc);
      chk("rst_abort_last", 32'(nl), 32'd0);
      decode(acc2 + 1, FL + 3, w, nb, nl, li, lc, fc);
      chk("rst_next_word", w & 32'hFFFFFF, 32'hABCDEF);
      chk("rst_next_bits", 32'(nb), 32'(FL));

      // Disabled while idle: no handshake
      i_en = 1'b0;
      i_word = 24'h000123;
      i_word_valid = 1'b1;
      repeat (2) tick();
      chk("en_low_ready", 32'(lg_ready[cyc-1]), 32'd0);
      i_word_valid = 1'b0;
      i_en = 1'b1;
      tick();
      chk("en_low_busy", 32'(lg_busy[cyc-1]), 32'd0);

      // Valid with a new word while busy is ignored until idle
      send(24'h0F0F0F, 1'b0, acc);
      repeat (5) tick();
      i_word = 24'hDEADBE;
      i_word_valid = 1'b1;
      send(24'hDEADBE, 1'b0, acc2);
      repeat (FL + 4) tick();
      chk("busy_acc_time", 32'(acc2 - acc), 32'(FL + GAP + 1));
      decode(acc + 1, acc2 - acc, w, nb, nl, li, lc, fc);
      chk("busy_word1", w & 32'hFFFFFF, 32'h0F0F0F);
      decode(acc2 + 1, FL + 3, w, nb, nl, li, lc, fc);
      chk("busy_word2", w & 32'hFFFFFF, 32'hDEADBE);

`ifdef WORD_SERIALIZER_PARITY_EN
      send(24'h000007, 1'b0, acc);
      repeat (FL + 4) tick();
      decode(acc + 1, FL + 3, w, nb, nl, li, lc, fc);
      chk("par7_bits",   32'(nb), 32'd25);
      chk("par7_bit24",  32'(w[24]), 32'd1);
      chk("par7_lastix", 32'(li), 32'd24);
      send(24'h000003, 1'b0, acc);
      repeat (FL + 4) tick();
      decode(acc + 1, FL + 3, w, nb, nl, li, lc, fc);
      chk("par3_bit24",  32'(w[24]), 32'd0);
      chk("par3_word",   w & 32'hFFFFFF, 32'h000003);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
